// File: rtl/register_file.sv
// register_file: 32 x 32-bit MIPS general-purpose register file, $0 hardwired to zero.
// Latency: reads are combinational (zero cycles); writes commit on the rising clk edge.
// Backpressure: none; one write and three reads are accepted every cycle.
//
// Ports:
//   clk        - system clock, all state changes on the rising edge
//   reset      - synchronous active-high reset; clears every register and writeCount
//   readReg1   - read port 1 address (rs), result on readData1 (ALU operand1)
//   readReg2   - read port 2 address (rt), result on readData2 (ALUSrc mux / store data)
//   debugReg   - debug read port address, result on debugData
//   writeReg   - write destination address (after RegDst mux)
//   writeData  - write value from the writeback path
//   regWrite   - write enable
//   writeCount - number of committed writes since reset (writes to $0 excluded), saturating
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    input  logic [ADDR_WIDTH-1:0] debugReg,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic [DATA_WIDTH-1:0] debugData,
    output logic [31:0]           writeCount
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [31:0]           r_write_count;

    logic                  w_wr_commit;
    logic                  w_fwd_en;
    logic [DATA_WIDTH-1:0] w_stored1;
    logic [DATA_WIDTH-1:0] w_stored2;
    logic [DATA_WIDTH-1:0] w_stored_dbg;

    // A write only commits when enabled and not aimed at $0. The enable is
    // tested first so an unknown writeReg with regWrite low cannot commit.
    assign w_wr_commit = regWrite && (writeReg != '0);

    // Forwarding is a pure compile-time choice; with BYPASS=0 the comparator
    // logic below collapses away.
    assign w_fwd_en = (BYPASS != 0) && w_wr_commit;

    // ------------------------------------------------------------------
    // Storage and write-commit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // Entry 0 is cleared too, but the read path never relies on it:
            // $0 is forced to zero at the output mux so it stays zero even
            // before the first reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i[ADDR_WIDTH-1:0]] <= '0;
            end
            r_write_count <= '0;
        end else if (w_wr_commit) begin
            r_mem[writeReg] <= writeData;
            // Rewriting an identical value still counts as a commit.
            if (r_write_count != COUNT_MAX) begin
                r_write_count <= r_write_count + 32'd1;
            end
        end
    end

    assign writeCount = r_write_count;

    // ------------------------------------------------------------------
    // Combinational read ports
    // ------------------------------------------------------------------
    // Priority per port: $0 -> zero, then same-cycle forward of the write
    // data (BYPASS=1 only), then the stored value. The $0 check sits above
    // the forward so a write aimed at $0 can never leak onto a read.
    function automatic logic [DATA_WIDTH-1:0] f_read_port(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  fwd_en,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [DATA_WIDTH-1:0] result;
        if (addr == '0) begin
            result = '0;
        end else if (fwd_en && (addr == waddr)) begin
            result = wdata;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    assign w_stored1    = r_mem[readReg1];
    assign w_stored2    = r_mem[readReg2];
    assign w_stored_dbg = r_mem[debugReg];

    always_comb begin
        readData1 = f_read_port(readReg1, w_stored1,    w_fwd_en, writeReg, writeData);
        readData2 = f_read_port(readReg2, w_stored2,    w_fwd_en, writeReg, writeData);
        debugData = f_read_port(debugReg, w_stored_dbg, w_fwd_en, writeReg, writeData);
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table-driven check of register_file with and without write bypass.
// Latency: reads checked 1 time unit after inputs change, before the following rising edge.
// Backpressure: none; one stimulus row per clock cycle.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [4:0]  debugReg;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        regWrite;

    logic [31:0] rd1_b, rd2_b, dbg_b, cnt_b;
    logic [31:0] rd1_n, rd2_n, dbg_n, cnt_n;

    int tests_run;
    int tests_failed;

    // Expected read-side view for one cycle, before that cycle's rising edge.
    typedef struct {
        string       name;
        logic [31:0] e1, e2, ed;   // BYPASS=1 instance
        logic [31:0] n1, n2, nd;   // BYPASS=0 instance
        logic [31:0] cnt;          // writeCount (same for both)
        bit          chk;
    } exp_t;

    typedef struct {
        bit          rst;
        bit          we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1, r2, d;
        exp_t        exp;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) u_dut_byp (
        .clk(clk), .reset(reset),
        .readReg1(readReg1), .readReg2(readReg2), .debugReg(debugReg),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .readData1(rd1_b), .readData2(rd2_b), .debugData(dbg_b), .writeCount(cnt_b)
    );

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) u_dut_nb (
        .clk(clk), .reset(reset),
        .readReg1(readReg1), .readReg2(readReg2), .debugReg(debugReg),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .readData1(rd1_n), .readData2(rd2_n), .debugData(dbg_n), .writeCount(cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(
        input string nm, input bit rst, input bit we, input logic [4:0] wr,
        input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
        input logic [4:0] d,
        input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ed,
        input logic [31:0] n1, input logic [31:0] n2, input logic [31:0] nd,
        input logic [31:0] cnt, input bit chk
    );
        vec_t v;
        v.rst = rst; v.we = we; v.wr = wr; v.wd = wd;
        v.r1 = r1; v.r2 = r2; v.d = d;
        v.exp.name = nm;
        v.exp.e1 = e1; v.exp.e2 = e2; v.exp.ed = ed;
        v.exp.n1 = n1; v.exp.n2 = n2; v.exp.nd = nd;
        v.exp.cnt = cnt; v.exp.chk = chk;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one row after the falling edge, queue its expectation, then pop
    // and compare once the combinational read paths have settled.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset     = v.rst;
        regWrite  = v.we;
        writeReg  = v.wr;
        writeData = v.wd;
        readReg1  = v.r1;
        readReg2  = v.r2;
        debugReg  = v.d;
        sb.push_back(v.exp);
        #1;
        e = sb.pop_front();
        if (e.chk) begin
            check({e.name, " byp.readData1"}, rd1_b, e.e1);
            check({e.name, " byp.readData2"}, rd2_b, e.e2);
            check({e.name, " byp.debugData"}, dbg_b, e.ed);
            check({e.name, " byp.writeCount"}, cnt_b, e.cnt);
            check({e.name, " nb.readData1"}, rd1_n, e.n1);
            check({e.name, " nb.readData2"}, rd2_n, e.n2);
            check({e.name, " nb.debugData"}, dbg_n, e.nd);
            check({e.name, " nb.writeCount"}, cnt_n, e.cnt);
        end
    endtask

    initial begin
        logic [4:0]  xaddr;
        tests_run    = 0;
        tests_failed = 0;
        xaddr        = 'x;
        reset = 1'b0; regWrite = 1'b0; writeReg = '0; writeData = '0;
        readReg1 = '0; readReg2 = '0; debugReg = '0;

        // Contents are undefined until the first reset edge: not checked.
        apply(mk("reset", 1, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0,
                 0, 0, 0, 0, 0, 0, 0, 0));

        // Sweep every address on all three read ports: all zero after reset.
        for (int a = 0; a < 32; a++) begin
            apply(mk($sformatf("sweep%0d", a), 0, 0, 5'd0, 32'h0,
                     5'(a), 5'(31 - a), 5'(a),
                     0, 0, 0, 0, 0, 0, 0, 1));
        end

        //            name       rst we wr     wd             r1     r2     d      e1/e2/ed (BYPASS=1)                        n1/n2/nd (BYPASS=0)                        cnt
        tbl.push_back(mk("wr8",     0, 1, 5'd8,  32'h0000_1010, 5'd8,  5'd9,  5'd8,  32'h0000_1010, 32'h0,         32'h0000_1010, 32'h0,         32'h0,         32'h0,         0, 1));
        tbl.push_back(mk("wr9",     0, 1, 5'd9,  32'h0000_1000, 5'd8,  5'd9,  5'd9,  32'h0000_1010, 32'h0000_1000, 32'h0000_1000, 32'h0000_1010, 32'h0,         32'h0,         1, 1));
        tbl.push_back(mk("rdback",  0, 0, 5'd0,  32'h0,         5'd8,  5'd9,  5'd0,  32'h0000_1010, 32'h0000_1000, 32'h0,         32'h0000_1010, 32'h0000_1000, 32'h0,         2, 1));
        tbl.push_back(mk("wr0",     0, 1, 5'd0,  32'hDEAD_BEEF, 5'd0,  5'd8,  5'd0,  32'h0,         32'h0000_1010, 32'h0,         32'h0,         32'h0000_1010, 32'h0,         2, 1));
        tbl.push_back(mk("rd0",     0, 0, 5'd0,  32'h0,         5'd0,  5'd9,  5'd0,  32'h0,         32'h0000_1000, 32'h0,         32'h0,         32'h0000_1000, 32'h0,         2, 1));
        tbl.push_back(mk("wr5",     0, 1, 5'd5,  32'h0001_0000, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         2, 1));
        tbl.push_back(mk("bypass5", 0, 1, 5'd5,  32'h0000_1010, 5'd8,  5'd5,  5'd5,  32'h0000_1010, 32'h0000_1010, 32'h0000_1010, 32'h0000_1010, 32'h0001_0000, 32'h0001_0000, 3, 1));
        tbl.push_back(mk("after5",  0, 0, 5'd0,  32'h0,         5'd5,  5'd5,  5'd5,  32'h0000_1010, 32'h0000_1010, 32'h0000_1010, 32'h0000_1010, 32'h0000_1010, 32'h0000_1010, 4, 1));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk($sformatf("wedis%0d", k), 0, 0, 5'd7, 32'hFFFF_FFFF, 5'd7, 5'd7, 5'd7,
                             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4, 1));
        end
        tbl.push_back(mk("samev",   0, 1, 5'd5,  32'h0000_1010, 5'd5,  5'd7,  5'd0,  32'h0000_1010, 32'h0,         32'h0,         32'h0000_1010, 32'h0,         32'h0,         4, 1));
        tbl.push_back(mk("xaddr",   0, 0, xaddr, 32'hFFFF_FFFF, 5'd8,  5'd9,  5'd5,  32'h0000_1010, 32'h0000_1000, 32'h0000_1010, 32'h0000_1010, 32'h0000_1000, 32'h0000_1010, 5, 1));
        tbl.push_back(mk("postx",   0, 0, 5'd0,  32'h0,         5'd1,  5'd31, 5'd8,  32'h0,         32'h0,         32'h0000_1010, 32'h0,         32'h0,         32'h0000_1010, 5, 1));
        foreach (tbl[i]) apply(tbl[i]);

        // Reset mid-program: populate $1..$3, then reset while a write to $4
        // is presented; that write is lost and everything reads zero.
        apply(mk("pop1", 0, 1, 5'd1, 32'h1111_1111, 5'd1, 5'd2, 5'd3,
                 32'h1111_1111, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5, 1));
        apply(mk("pop2", 0, 1, 5'd2, 32'h2222_2222, 5'd1, 5'd2, 5'd3,
                 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h1111_1111, 32'h0, 32'h0, 6, 1));
        apply(mk("pop3", 0, 1, 5'd3, 32'h3333_3333, 5'd1, 5'd2, 5'd3,
                 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h1111_1111, 32'h2222_2222, 32'h0, 7, 1));
        apply(mk("midrst", 1, 1, 5'd4, 32'h1234_5678, 5'd3, 5'd2, 5'd1,
                 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 8, 1));
        apply(mk("clr123", 0, 0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd3,
                 0, 0, 0, 0, 0, 0, 0, 1));
        apply(mk("clr34", 0, 0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd4,
                 0, 0, 0, 0, 0, 0, 0, 1));

        // Counting restarts from zero after reset; top register works.
        apply(mk("wr31", 0, 1, 5'd31, 32'hA5A5_A5A5, 5'd31, 5'd30, 5'd31,
                 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0, 0, 1));
        apply(mk("rd31", 0, 0, 5'd0, 32'h0, 5'd31, 5'd31, 5'd0,
                 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 1, 1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit MIPS general-purpose register file.
- Sits directly upstream of the ALU: read port 1 drives operand1; read port 2 feeds the operand2 mux (register vs. immediate).
- Write port is driven from the writeback path (ALU result or memory load data) once per clock.
- A third read-only debug port lets benches inspect any register without disturbing the datapath.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- BYPASS, 1, when 1, same-cycle write data is forwarded to read ports addressing the written register; when 0, reads return the pre-write value.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- readReg1  input  ADDR_WIDTH  address for read port 1 (rs).
- readReg2  input  ADDR_WIDTH  address for read port 2 (rt).
- debugReg  input  ADDR_WIDTH  address for debug read port.
- writeReg  input  ADDR_WIDTH  destination address (rd/rt after RegDst mux).
- writeData  input  DATA_WIDTH  value to write.
- regWrite  input  1  write enable.
- readData1  output  DATA_WIDTH  contents of readReg1, to ALU operand1.
- readData2  output  DATA_WIDTH  contents of readReg2, to ALUSrc mux / store data.
- debugData  output  DATA_WIDTH  contents of debugReg.
- writeCount  output  32  number of committed writes since reset, excluding writes to $0; saturates at 32'hFFFF_FFFF.

Behaviour:
- Storage: 2**ADDR_WIDTH registers. Entry 0 is hardwired zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0, including under bypass.
- Reads are combinational (zero latency): outputs follow the address inputs and stored contents within the same cycle, so a single-cycle CPU can compute in one clock.
- Write:
  - On rising clk with reset=0, regWrite=1, writeReg!=0: mem[writeReg] <= writeData.
  - The new value is visible on non-bypassed reads after that edge.
- Bypass (BYPASS=1): if regWrite=1, writeReg!=0 and readRegN==writeReg, then readDataN = writeData combinationally. The same rule applies to debugData.
- Two read ports may address the same register; both return the same value.
- writeCount:
  - Increments by 1 on each edge where a write commits (regWrite=1, writeReg!=0, reset=0).
  - Holds at 32'hFFFF_FFFF once reached.
  - Writing an identical value still counts.
- Reset (synchronous): on a rising clk with reset=1, all registers clear to 0 and writeCount clears to 0. regWrite is ignored on that edge.
  - After the reset edge, readData1, readData2 and debugData read 0 for all addresses, until a write commits. The exception is a BYPASS=1 forward, which is combinational.
  - Reset asserted mid-program clears state on the next edge; any write presented on that edge is lost.
- Before the first reset edge, contents are undefined; benches must reset first.
- X on writeReg while regWrite=0 must not corrupt state.

Test Plan:
- Reset then read all: assert reset for 1 cycle, sweep readReg1/readReg2/debugReg over 0..31 -> all outputs 32'h0000_0000; writeCount=0.
- Write/read-back: write 32'h0000_1010 to $8 and 32'h0000_1000 to $9 on successive edges, then readReg1=8, readReg2=9 -> readData1=32'h0000_1010, readData2=32'h0000_1000; writeCount=2.
- $0 protection: regWrite=1, writeReg=0, writeData=32'hDEAD_BEEF, one edge -> readData1 with readReg1=0 is 0; writeCount unchanged. With BYPASS=1, same-cycle read of $0 also returns 0.
- Bypass vs. no bypass: $5 holds 32'h0001_0000; present writeReg=5, writeData=32'h0000_1010, regWrite=1, readReg2=5.
  - BYPASS=1: readData2=32'h0000_1010 before the edge.
  - BYPASS=0: readData2=32'h0001_0000 before the edge, 32'h0000_1010 after it.
- Reset mid-operation: populate $1..$3, then assert reset while regWrite=1, writeReg=4, writeData=32'h1234_5678 -> after the edge $1..$4 read 0 and writeCount=0.
- Write disabled: regWrite=0, writeReg=7, writeData=32'hFFFF_FFFF for 3 cycles -> $7 is unchanged (0 after reset); writeCount is unchanged.
